// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, debounce filter and a press/long-press FSM.
// Optional auto-repeat while held is enabled by defining BUTTON_AUTO_REPEAT_EN.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press,
  output logic long_press,
  output logic held
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LG_W = $clog2(LONG_CYCLES + 1);

  // state   | meaning
  // IDLE    | released, waiting for debounced level to rise
  // PRESSED | press pulse issued, timing towards long_press
  // LONG    | long_press issued, held until release
  // REPEAT  | auto-repeat press pulses while held (BUTTON_AUTO_REPEAT_EN only)
`ifdef BUTTON_AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, PRESSED, LONG, REPEAT} state_t;
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
  logic [RP_W-1:0] rpt_cnt, rpt_cnt_nx;
`else
  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;
`endif

  state_t          state, state_nx;
  logic            sync1, sync2;
  logic [DB_W-1:0] db_cnt;
  logic [LG_W-1:0] hold_cnt, hold_cnt_nx;
  logic            press_nx, long_nx;

  // Synchroniser and debounce filter
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      held   <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      if (sync2 == held) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        held   <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      press      <= 1'b0;
      long_press <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rpt_cnt    <= '0;
`endif
    end else begin
      state      <= state_nx;
      hold_cnt   <= hold_cnt_nx;
      press      <= press_nx;
      long_press <= long_nx;
`ifdef BUTTON_AUTO_REPEAT_EN
      rpt_cnt    <= rpt_cnt_nx;
`endif
    end
  end

  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    press_nx    = 1'b0;
    long_nx     = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
    rpt_cnt_nx  = rpt_cnt;
`endif
    // A release always wins, so a pulse due in the release cycle is dropped.
    if (state != IDLE && !held) begin
      state_nx    = IDLE;
      hold_cnt_nx = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rpt_cnt_nx  = '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (held) begin
            state_nx    = PRESSED;
            press_nx    = 1'b1;
            hold_cnt_nx = '0;
          end
        end
        PRESSED: begin
          if (hold_cnt == LG_W'(LONG_CYCLES - 1)) begin
            state_nx    = LONG;
            long_nx     = 1'b1;
            hold_cnt_nx = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
            rpt_cnt_nx  = '0;
`endif
          end else begin
            hold_cnt_nx = hold_cnt + LG_W'(1);
          end
        end
`ifdef BUTTON_AUTO_REPEAT_EN
        // LONG counts as the first repeat cycle so the first repeat lands
        // exactly REPEAT_CYCLES after long_press.
        LONG, REPEAT: begin
          state_nx = REPEAT;
          if (rpt_cnt == RP_W'(REPEAT_CYCLES - 1)) begin
            press_nx   = 1'b1;
            rpt_cnt_nx = '0;
          end else begin
            rpt_cnt_nx = rpt_cnt + RP_W'(1);
          end
        end
`else
        LONG: state_nx = LONG;
`endif
        default: begin
          state_nx    = IDLE;
          hold_cnt_nx = '0;
        end
      endcase
    end
  end

endmodule
